muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; even, >=8.
REQ-002 SHALL have ports in this order:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- a, b  in  WIDTH  operands.
- func  in  mdfunc_t  operation (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- word  in  1  32-bit op on low halves; result sign-extended to WIDTH.
- flush  in  1  abandon the in-flight operation.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- c  out  WIDTH  result.

Function
REQ-003 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-004 SHALL drive in_ready=1 only in IDLE; accept = in_valid & in_ready; operands, func and word latched on accept.
REQ-005 SHALL compute one bit per cycle in BUSY: shift-add multiply, restoring divide on magnitudes, sign fix-up at the end.
REQ-006 SHALL use N = WIDTH iterations (WIDTH/2 when word=1); out_valid rises exactly N+1 cycles after the accept edge.
REQ-007 SHALL return the low half for MUL and the high half for MULH (s*s), MULHSU (s*u) and MULHU (u*u).
REQ-008 SHALL truncate DIV/REM toward zero, with the remainder taking the sign of the dividend.
REQ-009 SHALL take a fast path when the divisor is zero, going straight to DONE one cycle after accept:
- DIV/DIVU -> all ones.
- REM/REMU -> dividend.
REQ-010 SHALL take a fast path for signed overflow (DIV/REM of most-negative by -1), one cycle after accept:
- DIV -> dividend.
- REM -> 0.
REQ-011 SHALL, when word=1, use only a[31:0] and b[31:0] (signed or unsigned per func) and return bits [31:0] of the result sign-extended to WIDTH; word fast paths use the 32-bit values.
REQ-012 SHALL hold out_valid and a stable c in DONE until out_ready=1, then return to IDLE on the next cycle; in_ready is 0 throughout DONE.
REQ-013 SHALL, on flush in BUSY or DONE, go to IDLE next cycle, drop out_valid and discard the result; flush in IDLE has no effect.
REQ-014 SHALL let flush win over out_ready in the same cycle; the result counts as not delivered.
REQ-015 SHALL ignore a, b, func and word outside the accept cycle.

Reset
REQ-016 SHALL make reset, when high at a rising edge, put the unit in IDLE with out_valid=0, c=0, in_ready=1 on the following cycle, aborting any operation.
REQ-017 SHALL give reset priority over flush and accept.

Structure
REQ-018 SHALL define mdfunc_t in the shared pipes package alongside alufunc_t.
REQ-019 SHALL keep the FSM state enum local to the module.
REQ-020 SHALL contain a single sub-module, muldiv_iter (one multiply/divide step), instantiated once.
REQ-021 SHALL not instantiate a combinational multiplier or divider.

Verification (WIDTH=64)
REQ-022 SHALL cover MUL a=3 b=5: c=15, out_valid 65 cycles after accept; MULHU a=b=all-ones: c=0xFFFF_FFFF_FFFF_FFFE.
REQ-023 SHALL cover DIV a=-7 b=2: c=-3; REM a=-7 b=2: c=-1; DIVU a=100 b=7: c=14.
REQ-024 SHALL cover DIVU a=5 b=0: c=all-ones; REM a=5 b=0: c=5; DIV a=0x8000_0000_0000_0000 b=-1: c=a. Each with out_valid one cycle after accept.
REQ-025 SHALL cover word DIV a=0x8000_0000 b=1: c=0xFFFF_FFFF_8000_0000 at 33 cycles; word MUL a=0x1_0000_0002 b=3: c=6.
REQ-026 SHALL cover out_ready held low 10 cycles in DONE: c stable and in_ready=0 throughout; then a pulse gives IDLE next cycle.
REQ-027 SHALL cover flush at BUSY cycle 20 and reset mid-DONE: no out_valid, and in_ready=1 next cycle.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared pipeline package: ALU and multiply/divide function codes plus
// small decode helpers used by the iterative multiply/divide unit.
package pipes_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alufunc_t;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } mdfunc_t;

    function automatic logic md_is_div(input mdfunc_t f);
        return f inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_rem(input mdfunc_t f);
        return f inside {MD_REM, MD_REMU};
    endfunction

    // MUL only needs the low half, which is identical for signed and unsigned.
    function automatic logic md_a_signed(input mdfunc_t f);
        return f inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_b_signed(input mdfunc_t f);
        return f inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One step of the iterative unit: a shift-add multiply step or a restoring
// divide step, operating on unsigned magnitudes held in a hi/lo register pair.
module muldiv_iter #(
    parameter int WIDTH = 64
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift the pair right. Divide: shift in the next dividend bit and keep the
    // trial subtraction only if it did not go negative.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, operand_i};
        ge      = ~diff[WIDTH];
        if (is_div) begin
            hi_o = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ge};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit with valid/ready handshakes.
// Operands are converted to magnitudes on accept, one bit is processed per
// cycle, and signs are restored in a final fix-up cycle.
module muldiv_unit
    import pipes_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mdfunc_t          func,
    input  logic             word,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    mdfunc_t          func_q, func_d;
    logic             word_q, word_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             fast_q, fast_d;
    logic [WIDTH-1:0] fast_res_q, fast_res_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
    logic             a_neg, b_neg, div_zero, overflow;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_s;
    logic [WIDTH-1:0] quo, quo_s, rem_s, final_res;
    logic [CW-1:0]    n_iter;

    function automatic logic [WIDTH-1:0] word_fmt(input logic w, input logic [WIDTH-1:0] v);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Operand preparation for the accept cycle: extension, magnitudes, fast paths.
    always_comb begin
        if (word) begin
            a_ext = md_a_signed(func) ? {{HALF{a[HALF-1]}}, a[HALF-1:0]} : {{HALF{1'b0}}, a[HALF-1:0]};
            b_ext = md_b_signed(func) ? {{HALF{b[HALF-1]}}, b[HALF-1:0]} : {{HALF{1'b0}}, b[HALF-1:0]};
            min_neg = {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}};
        end else begin
            a_ext   = a;
            b_ext   = b;
            min_neg = {1'b1, {(WIDTH-1){1'b0}}};
        end
        a_neg    = md_a_signed(func) & a_ext[WIDTH-1];
        b_neg    = md_b_signed(func) & b_ext[WIDTH-1];
        a_mag    = a_neg ? ('0 - a_ext) : a_ext;
        b_mag    = b_neg ? ('0 - b_ext) : b_ext;
        div_zero = md_is_div(func) && (b_ext == '0);
        overflow = (func inside {MD_DIV, MD_REM}) && (a_ext == min_neg) && (b_ext == '1);
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div    (md_is_div(func_q)),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .operand_i (b_mag_q),
        .hi_o      (step_hi),
        .lo_o      (step_lo)
    );

    // Sign fix-up and result selection from the finished hi/lo pair.
    always_comb begin
        prod_raw = word_q ? ({hi_q, lo_q} >> HALF) : {hi_q, lo_q};
        prod_s   = (a_neg_q ^ b_neg_q) ? ('0 - prod_raw) : prod_raw;
        quo      = word_q ? {{HALF{1'b0}}, lo_q[HALF-1:0]} : lo_q;
        quo_s    = (a_neg_q ^ b_neg_q) ? ('0 - quo) : quo;
        rem_s    = a_neg_q ? ('0 - hi_q) : hi_q;
        n_iter   = word_q ? CW'(HALF) : CW'(WIDTH);
        case (func_q)
            MD_MUL:                      final_res = prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:
                final_res = word_q ? {{HALF{1'b0}}, prod_s[WIDTH-1:HALF]} : prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:             final_res = quo_s;
            default:                     final_res = rem_s;
        endcase
    end

    // Next-state logic for the IDLE -> BUSY -> DONE handshake FSM and datapath.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        func_d      = func_q;
        word_d      = word_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        fast_d      = fast_q;
        fast_res_d  = fast_res_q;
        b_mag_d     = b_mag_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_BUSY;
                    in_ready_d = 1'b0;
                    func_d     = func;
                    word_d     = word;
                    a_neg_d    = a_neg;
                    b_neg_d    = b_neg;
                    b_mag_d    = b_mag;
                    fast_d     = div_zero | overflow;
                    if (div_zero) fast_res_d = md_is_rem(func) ? a_ext : '1;
                    else          fast_res_d = md_is_rem(func) ? '0 : a_ext;
                    hi_d       = '0;
                    lo_d       = (md_is_div(func) && word) ? (a_mag << HALF) : a_mag;
                    cnt_d      = '0;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else if (fast_q) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    c_d         = word_fmt(word_q, fast_res_q);
                end else if (cnt_q == n_iter) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    c_d         = word_fmt(word_q, final_res);
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    c_d         = '0;
                    in_ready_d  = 1'b1;
                end else if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation and overrides flush and accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            func_q      <= MD_MUL;
            word_q      <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            fast_q      <= 1'b0;
            fast_res_q  <= '0;
            b_mag_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            func_q      <= func_d;
            word_q      <= word_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            fast_q      <= fast_d;
            fast_res_q  <= fast_res_d;
            b_mag_q     <= b_mag_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule
